// File: rtl/aww_types_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM state, the
// grouped control word, scoreboard depth limit and a saturating increment.
package aww_types_pkg;

    localparam int LOAD_LAT_MAX = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic pc_wen;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic halted;
    } pipe_ctrl_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_scoreboard.sv
// Shift register of in-flight load destinations; flags a read-after-load hazard
// against the ID-stage sources. Register 0 never matches.
module load_scoreboard
    import aww_types_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_shift_en,
    input  logic             i_ex_load,
    input  logic [REG_W-1:0] i_ex_wsel,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    output logic             o_hz
);

    localparam int DEPTH = (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX :
                           ((LOAD_LAT < 1) ? 1 : LOAD_LAT);

    logic [DEPTH-1:0] r_vld;
    logic [REG_W-1:0] r_reg [DEPTH];
    logic [DEPTH-1:0] w_match;
    logic             w_ex_vld;
    logic             w_ex_match;

    assign w_ex_vld   = i_ex_load && (i_ex_wsel != '0);
    assign w_ex_match = w_ex_vld && ((i_ex_wsel == i_id_rs) ||
                                     (i_id_uses_rt && (i_ex_wsel == i_id_rt)));

    // Entry 0 captures the EX instruction as it moves into EX/MEM
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_vld[0] <= 1'b0;
            r_reg[0] <= '0;
        end else if (i_shift_en) begin
            r_vld[0] <= w_ex_vld;
            r_reg[0] <= i_ex_wsel;
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_shift
        // Older entries follow entry 0 on the same advance
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                r_vld[g] <= 1'b0;
                r_reg[g] <= '0;
            end else if (i_shift_en) begin
                r_vld[g] <= r_vld[g-1];
                r_reg[g] <= r_reg[g-1];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign w_match[g] = r_vld[g] && ((r_reg[g] == i_id_rs) ||
                                         (i_id_uses_rt && (r_reg[g] == i_id_rt)));
    end

    assign o_hz = w_ex_match || (|w_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/stall controller: load-use scoreboard, branch squash,
// memory-wait freeze and halt drain. HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl
    import aww_types_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic             ex_load,
    input  logic             ex_halt,
    input  logic             ex_branch_taken,
    output logic             pc_wen,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    hazard_state_t    r_state, w_state_nxt, w_run_state;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_run_cnt;
    pipe_ctrl_t       w_ctrl, w_run_ctrl, w_out;
    logic             w_hz, w_mem_busy, w_freeze;

    assign w_mem_busy = mem_req && !dhit;
    assign w_freeze   = (r_state == MEM_WAIT) ? !dhit : w_mem_busy;

    load_scoreboard #(.REG_W(REG_W), .LOAD_LAT(LOAD_LAT)) u_sb (
        .CLK          (CLK),
        .nRST         (nRST),
        .i_shift_en   (w_out.exmem_en),
        .i_ex_load    (ex_load),
        .i_ex_wsel    (ex_wsel),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rt (id_uses_rt),
        .o_hz         (w_hz)
    );

    // Normal-flow rules once memory is not holding the pipe; branch beats hazard
    always_comb begin
        w_run_ctrl  = '0;
        w_run_state = RUN;
        w_run_cnt   = r_cnt;
        if (ex_halt) begin
            w_run_ctrl.ifid_flush = 1'b1;
            w_run_ctrl.idex_flush = 1'b1;
            w_run_ctrl.exmem_en   = 1'b1;
            w_run_ctrl.memwb_en   = 1'b1;
            w_run_state           = DRAIN;
            w_run_cnt             = CNT_W'(DRAIN_CYC);
        end else if (ex_branch_taken) begin
            w_run_ctrl          = '1;
            w_run_ctrl.halted   = 1'b0;
        end else if (w_hz || !ihit) begin
            w_run_ctrl.idex_en    = 1'b1;
            w_run_ctrl.idex_flush = 1'b1;
            w_run_ctrl.exmem_en   = 1'b1;
            w_run_ctrl.memwb_en   = 1'b1;
        end else begin
            w_run_ctrl.pc_wen   = 1'b1;
            w_run_ctrl.ifid_en  = 1'b1;
            w_run_ctrl.idex_en  = 1'b1;
            w_run_ctrl.exmem_en = 1'b1;
            w_run_ctrl.memwb_en = 1'b1;
        end
    end

    // FSM next state and control word
    always_comb begin
        w_ctrl      = '0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_freeze) begin
                    w_state_nxt = MEM_WAIT;
                end else begin
                    w_ctrl      = w_run_ctrl;
                    w_state_nxt = w_run_state;
                    w_cnt_nxt   = w_run_cnt;
                end
            end
            DRAIN: begin
                w_ctrl.exmem_en = !w_mem_busy;
                w_ctrl.memwb_en = !w_mem_busy;
                if (r_cnt == '0) begin
                    w_state_nxt = HALTED;
                end else if (!w_mem_busy) begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_state_nxt = (r_cnt == CNT_W'(1)) ? HALTED : DRAIN;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            HALTED: begin
                w_ctrl.halted = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // State and drain counter
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_out      = nRST ? w_ctrl : '0;
    assign pc_wen     = w_out.pc_wen;
    assign ifid_en    = w_out.ifid_en;
    assign ifid_flush = w_out.ifid_flush;
    assign idex_en    = w_out.idex_en;
    assign idex_flush = w_out.idex_flush;
    assign exmem_en   = w_out.exmem_en;
    assign memwb_en   = w_out.memwb_en;
    assign halted     = w_out.halted;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;
    logic        w_in_run, w_stall_ev, w_flush_ev;

    assign w_in_run   = (r_state == RUN) || (r_state == MEM_WAIT);
    assign w_stall_ev = w_in_run && (w_freeze || (w_hz && !ex_halt && !ex_branch_taken));
    assign w_flush_ev = w_in_run && !w_freeze && (ex_halt || ex_branch_taken);

    // Saturating performance counters
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_ev) r_stall_cnt <= sat_inc32(r_stall_cnt);
            if (w_flush_ev) r_flush_cnt <= sat_inc32(r_flush_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a rule model.
module tb_pipe_hazard_ctrl;

    localparam int REG_W     = 5;
    localparam int LOAD_LAT  = 1;
    localparam int DRAIN_CYC = 2;

    // {pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted}
    localparam logic [7:0] V_NORMAL = 8'b1101_0110;
    localparam logic [7:0] V_STALL  = 8'b0001_1110;
    localparam logic [7:0] V_BRANCH = 8'b1111_1110;
    localparam logic [7:0] V_HALT   = 8'b0010_1110;
    localparam logic [7:0] V_DRAIN  = 8'b0000_0110;
    localparam logic [7:0] V_HALTED = 8'b0000_0001;
    localparam logic [7:0] V_FREEZE = 8'b0000_0000;

`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             nRST, ihit, dhit, mem_req, id_uses_rt, ex_load, ex_halt, ex_branch_taken;
    logic [REG_W-1:0] id_rs, id_rt, ex_wsel;
    logic             pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
    logic [31:0]      stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .DRAIN_CYC(DRAIN_CYC)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_wsel(ex_wsel), .ex_load(ex_load), .ex_halt(ex_halt),
        .ex_branch_taken(ex_branch_taken),
        .pc_wen(pc_wen), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    wire [7:0] dut_vec = {pc_wen, ifid_en, ifid_flush, idex_en, idex_flush,
                          exmem_en, memwb_en, halted};

    // Model: mode 0=running 1=waiting on memory 2=draining 3=halted
    int     m_mode = 0;
    int     m_cnt  = 0;
    int     sb[$];
    longint m_stall = 0;
    longint m_flush = 0;
    bit     m_valid = 1'b0;

    function automatic bit reads(int r);
        return (r != 0) && ((r == int'(id_rs)) || (id_uses_rt && (r == int'(id_rt))));
    endfunction

    function automatic void model(output logic [7:0] o, output int nmode, output int ncnt,
                                  output bit st, output bit fl);
        bit busy = mem_req && !dhit;
        bit run  = 1'b0;
        bit hz;
        o = 8'h00; nmode = m_mode; ncnt = m_cnt; st = 1'b0; fl = 1'b0;
        if (!nRST) return;
        case (m_mode)
            0: if (busy) begin nmode = 1; st = 1'b1; end else run = 1'b1;
            1: if (dhit) begin nmode = 0; run = 1'b1; end else st = 1'b1;
            2: begin
                if (!busy) begin o[2] = 1'b1; o[1] = 1'b1; end
                if (m_cnt == 0) nmode = 3;
                else if (!busy) begin ncnt = m_cnt - 1; if (ncnt == 0) nmode = 3; end
            end
            default: o[0] = 1'b1;
        endcase
        if (run) begin
            hz = ex_load && reads(int'(ex_wsel));
            foreach (sb[i]) if (reads(sb[i])) hz = 1'b1;
            if (ex_halt) begin
                o = V_HALT; nmode = 2; ncnt = DRAIN_CYC; fl = 1'b1;
            end else if (ex_branch_taken) begin
                o = V_BRANCH; fl = 1'b1;
            end else if (hz) begin
                o = V_STALL; st = 1'b1;
            end else if (!ihit) begin
                o = V_STALL;
            end else begin
                o = V_NORMAL;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model state advance at each rising edge
    initial begin
        logic [7:0] o; int nm, nc; bit s, f;
        forever begin
            @(posedge CLK);
            model(o, nm, nc, s, f);
            if (!nRST) begin
                m_mode = 0; m_cnt = 0; m_stall = 0; m_flush = 0; m_valid = 1'b1;
                sb = {};
                repeat (LOAD_LAT) sb.push_back(0);
            end else if (m_valid) begin
                if (o[2]) begin
                    sb.push_front(ex_load ? int'(ex_wsel) : 0);
                    void'(sb.pop_back());
                end
                if (PERF != 0) begin
                    if (s && m_stall < 64'hFFFF_FFFF) m_stall++;
                    if (f && m_flush < 64'hFFFF_FFFF) m_flush++;
                end
                m_mode = nm; m_cnt = nc;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        logic [7:0] o; int nm, nc; bit s, f;
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                model(o, nm, nc, s, f);
                chk("ctrl_vs_model", dut_vec, o);
                chk("stall_cnt_vs_model", stall_cnt, m_stall);
                chk("flush_cnt_vs_model", flush_cnt, m_flush);
            end
        end
    end

    task automatic nxt();
        @(posedge CLK); #1;
        nRST = 1'b1; ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_wsel = '0; ex_load = 1'b0; ex_halt = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] c0;
        int halt_run;
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_wsel = '0; ex_load = 1'b0; ex_halt = 1'b0; ex_branch_taken = 1'b0;

        @(posedge CLK); smp(); chk("reset_cyc1", dut_vec, V_FREEZE);
        @(posedge CLK); smp(); chk("reset_cyc2", dut_vec, V_FREEZE);
        nxt(); smp(); chk("after_reset", dut_vec, V_NORMAL);
        chk("after_reset_halted", halted, 1'b0);

        nxt(); ex_load = 1'b1; ex_wsel = 5'd8; id_rs = 5'd1; smp(); chk("load_in_ex", dut_vec, V_NORMAL);
        nxt(); id_rs = 5'd8; smp(); chk("load_use_stall", dut_vec, V_STALL);
        nxt(); id_rs = 5'd8; smp(); chk("load_use_clear", dut_vec, V_NORMAL);

        nxt(); ex_load = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; smp(); chk("r0_ex", dut_vec, V_NORMAL);
        nxt(); id_rs = 5'd0; smp(); chk("r0_sb", dut_vec, V_NORMAL);

        nxt(); ex_load = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5; smp(); chk("rt_unused", dut_vec, V_NORMAL);
        nxt(); id_rt = 5'd5; smp(); chk("rt_unused_sb", dut_vec, V_NORMAL);
        nxt(); ex_load = 1'b1; ex_wsel = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1; smp();
        chk("rt_used_stall", dut_vec, V_STALL);

        c0 = flush_cnt;
        nxt(); ex_load = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3; ex_branch_taken = 1'b1; smp();
        chk("branch_over_hz", dut_vec, V_BRANCH);
        nxt(); smp(); chk("after_branch", dut_vec, V_NORMAL);
        chk("flush_delta", flush_cnt - c0, 32'(PERF));

        nxt(); ex_load = 1'b1; ex_wsel = 5'd9; smp(); chk("pre_freeze", dut_vec, V_NORMAL);
        c0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            nxt(); mem_req = 1'b1; dhit = 1'b0; id_rs = 5'd9; smp();
            chk("mem_freeze", dut_vec, V_FREEZE);
        end
        nxt(); mem_req = 1'b1; dhit = 1'b1; id_rs = 5'd9; smp(); chk("freeze_release_sb_held", dut_vec, V_STALL);
        nxt(); id_rs = 5'd9; smp(); chk("freeze_done", dut_vec, V_NORMAL);
        chk("stall_delta", stall_cnt - c0, 32'(4 * PERF));

        nxt(); ex_halt = 1'b1; smp(); chk("halt_ex", dut_vec, V_HALT);
        nxt(); smp(); chk("drain_1", dut_vec, V_DRAIN);
        nxt(); smp(); chk("drain_2", dut_vec, V_DRAIN);
        nxt(); smp(); chk("halted_1", dut_vec, V_HALTED);
        nxt(); ex_branch_taken = 1'b1; smp(); chk("halted_sticky", dut_vec, V_HALTED);
        nxt(); nRST = 1'b0; smp(); chk("reset_from_halt", dut_vec, V_FREEZE);
        nxt(); smp(); chk("run_after_halt", dut_vec, V_NORMAL);
        chk("halted_cleared", halted, 1'b0);

        halt_run = 0;
        for (int n = 0; n < 4000; n++) begin
            nxt();
            nRST            = !(($urandom_range(0, 299) == 0) || (halt_run > 4));
            ihit            = ($urandom_range(0, 7) != 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            dhit            = ($urandom_range(0, 1) == 0);
            id_rs           = REG_W'($urandom_range(0, 3));
            id_rt           = REG_W'($urandom_range(0, 3));
            id_uses_rt      = ($urandom_range(0, 1) == 0);
            ex_wsel         = REG_W'($urandom_range(0, 3));
            ex_load         = ($urandom_range(0, 2) == 0);
            ex_halt         = ($urandom_range(0, 119) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            smp();
            halt_run = (m_mode == 3) ? halt_run + 1 : 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
